// File: rtl/arith_enc_ctrl.sv
// Sequencing controller for the arithmetic-encoder interval datapath: issues a symbol to
// the bound_calc pair, latches the new interval, renormalises and streams out the code bits.
module arith_enc_ctrl #(
    parameter int unsigned BC_LAT = 5,
    parameter int unsigned PEND_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [15:0] sym_prob_upper,
    input  logic [15:0] sym_prob_lower,
    input  logic [16:0] sym_inv_total,
    input  logic        sym_last,
    output logic [15:0] bc_work_upper,
    output logic [15:0] bc_work_lower,
    output logic [15:0] bc_prob_upper,
    output logic [15:0] bc_prob_lower,
    output logic [16:0] bc_prob_range,
    input  logic [15:0] bc_upper_res,
    input  logic [15:0] bc_lower_res,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_out,
    output logic        done,
    output logic        pend_ovf
);

    localparam int unsigned CNT_W = $clog2(BC_LAT + 1);

    typedef enum logic [2:0] {IDLE, CALC, RENORM, EMIT, FLUSH, FDONE} state_t;

    state_t            state;
    logic [15:0]       work_upper;
    logic [15:0]       work_lower;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] emit_rem;
    logic [CNT_W-1:0]  lat_cnt;
    logic              last_r;
    logic              emit_bit;
    logic              flushing;

    logic              e1;
    logic              e2;
    logic              e3;
    logic              pend_sat;
    logic [PEND_W-1:0] pend_inc;
    logic [15:0]       e3_upper;
    logic [15:0]       e3_lower;

    always_comb begin
        e1       = ~work_upper[15] & ~work_lower[15];
        e2       = work_upper[15] & work_lower[15];
        e3       = (work_lower[15:14] == 2'b01) && (work_upper[15:14] == 2'b10);
        pend_sat = &pending;
        pend_inc = pend_sat ? pending : pending + 1'b1;
        e3_upper = work_upper - 16'h4000;
        e3_lower = work_lower - 16'h4000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            work_upper    <= '1;
            work_lower    <= '0;
            pending       <= '0;
            emit_rem      <= '0;
            lat_cnt       <= '0;
            last_r        <= 1'b0;
            emit_bit      <= 1'b0;
            flushing      <= 1'b0;
            sym_ready     <= 1'b1;
            bit_valid     <= 1'b0;
            bit_out       <= 1'b0;
            done          <= 1'b0;
            pend_ovf      <= 1'b0;
            bc_work_upper <= '0;
            bc_work_lower <= '0;
            bc_prob_upper <= '0;
            bc_prob_lower <= '0;
            bc_prob_range <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sym_valid && sym_ready) begin
                        bc_work_upper <= work_upper;
                        bc_work_lower <= work_lower;
                        bc_prob_upper <= sym_prob_upper;
                        bc_prob_lower <= sym_prob_lower;
                        bc_prob_range <= sym_inv_total;
                        last_r        <= sym_last;
                        lat_cnt       <= '0;
                        sym_ready     <= 1'b0;
                        state         <= CALC;
                    end
                end
                CALC: begin
                    if (lat_cnt == CNT_W'(BC_LAT - 1)) begin
                        work_upper <= bc_upper_res;
                        work_lower <= bc_lower_res;
                        state      <= RENORM;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RENORM: begin
                    if (e1 || e2) begin
                        emit_bit  <= e2;
                        bit_out   <= e2;
                        bit_valid <= 1'b1;
                        emit_rem  <= pending;
                        flushing  <= 1'b0;
                        state     <= EMIT;
                    end else if (e3) begin
                        work_lower <= {e3_lower[14:0], 1'b0};
                        work_upper <= {e3_upper[14:0], 1'b1};
                        pending    <= pend_inc;
                        if (pend_sat)
                            pend_ovf <= 1'b1;
                    end else if (last_r) begin
                        state <= FLUSH;
                    end else begin
                        sym_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                // emit_rem counts the complement bits still owed after the one on bit_out
                EMIT: begin
                    if (bit_ready) begin
                        if (emit_rem == '0) begin
                            bit_valid  <= 1'b0;
                            pending    <= '0;
                            work_lower <= {work_lower[14:0], 1'b0};
                            work_upper <= {work_upper[14:0], 1'b1};
                            if (flushing) begin
                                done  <= 1'b1;
                                state <= FDONE;
                            end else begin
                                state <= RENORM;
                            end
                        end else begin
                            emit_rem <= emit_rem - 1'b1;
                            bit_out  <= ~emit_bit;
                        end
                    end
                end
                FLUSH: begin
                    pending   <= pend_inc;
                    if (pend_sat)
                        pend_ovf <= 1'b1;
                    emit_bit  <= |work_lower[15:14];
                    bit_out   <= |work_lower[15:14];
                    bit_valid <= 1'b1;
                    emit_rem  <= pend_inc;
                    flushing  <= 1'b1;
                    state     <= EMIT;
                end
                FDONE: begin
                    work_upper <= '1;
                    work_lower <= '0;
                    pending    <= '0;
                    flushing   <= 1'b0;
                    sym_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    sym_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_enc_ctrl.sv
// Directed bench for arith_enc_ctrl: a symbol-level interval model predicts the bit stream,
// done pulses and per-symbol cycle counts; a negedge process checks the DUT every cycle.
module tb_arith_enc_ctrl;

    localparam int unsigned BC_LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [15:0] sym_prob_upper = '0;
    logic [15:0] sym_prob_lower = '0;
    logic [16:0] sym_inv_total = '0;
    logic        sym_last = 1'b0;
    logic [15:0] bc_work_upper;
    logic [15:0] bc_work_lower;
    logic [15:0] bc_prob_upper;
    logic [15:0] bc_prob_lower;
    logic [16:0] bc_prob_range;
    logic [15:0] bc_upper_res = 16'hDEAD;
    logic [15:0] bc_lower_res = 16'hBEEF;
    logic        bit_valid;
    logic        bit_ready = 1'b1;
    logic        bit_out;
    logic        done;
    logic        pend_ovf;

    arith_enc_ctrl #(.BC_LAT(BC_LAT), .PEND_W(16)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_prob_upper(sym_prob_upper), .sym_prob_lower(sym_prob_lower),
        .sym_inv_total(sym_inv_total), .sym_last(sym_last),
        .bc_work_upper(bc_work_upper), .bc_work_lower(bc_work_lower),
        .bc_prob_upper(bc_prob_upper), .bc_prob_lower(bc_prob_lower),
        .bc_prob_range(bc_prob_range),
        .bc_upper_res(bc_upper_res), .bc_lower_res(bc_lower_res),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
        .done(done), .pend_ovf(pend_ovf)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: interval, pending count, outstanding bits and done pulses
    int unsigned m_u = 65535;
    int unsigned m_l = 0;
    int unsigned m_p = 0;
    int unsigned last_nb = 0;
    int unsigned done_pending = 0;
    bit          exp_bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input bit b, input int unsigned n_comp);
        exp_bits.push_back(b);
        for (int unsigned i = 0; i < n_comp; i++)
            exp_bits.push_back(!b);
    endtask

    // Interval scaling from the datapath result; edges = clock edges from accept to idle
    task automatic model_sym(input int unsigned ru, input int unsigned rl, input bit last,
                             output int unsigned edges);
        int unsigned u, l, ev, nb;
        bit go;
        u = ru; l = rl; ev = 0; nb = 0; go = 1'b1;
        while (go && ev < 200) begin
            ev++;
            if ((u < 32768 && l < 32768) || (u >= 32768 && l >= 32768)) begin
                push_run(u >= 32768, m_p);
                nb += 1 + m_p;
                m_p = 0;
                l = (l * 2) % 65536;
                u = (u * 2 + 1) % 65536;
            end else if (l >= 16384 && l < 32768 && u >= 32768 && u < 49152) begin
                l = ((l - 16384) * 2) % 65536;
                u = ((u - 16384) * 2 + 1) % 65536;
                if (m_p < 65535) m_p++;
            end else begin
                go = 1'b0;
            end
        end
        edges = BC_LAT + ev + nb;
        if (last) begin
            if (m_p < 65535) m_p++;
            push_run(l >= 16384, m_p);
            nb += 1 + m_p;
            edges += 2 + 1 + m_p;
            u = 65535; l = 0; m_p = 0;
            done_pending++;
        end
        m_u = u; m_l = l; last_nb = nb;
    endtask

    // Per-cycle checker: bit stream order, handshake hold, done pulse, overflow flag
    bit   prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("pend_ovf", pend_ovf, 0);
            if (prev_stall) begin
                chk("hold_valid", bit_valid, 1);
                chk("hold_bit", bit_out, prev_bit);
            end
            if (bit_valid && bit_ready) begin
                if (exp_bits.size() == 0)
                    chk("unexpected_bit", 1, 0);
                else
                    chk("bit_out", bit_out, exp_bits.pop_front());
            end
            if (done) begin
                chk("done_expected", done_pending > 0, 1);
                chk("done_after_bits", exp_bits.size(), 0);
                if (done_pending > 0) done_pending--;
            end
            prev_stall = bit_valid && !bit_ready;
            prev_bit = bit_out;
        end
    end

    task automatic issue(input logic [15:0] pu, input logic [15:0] pl, input logic [16:0] inv,
                         input bit last, input logic [15:0] ru, input logic [15:0] rl,
                         output int unsigned cyc0, output int unsigned edges);
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (!sym_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_issue", sym_ready, 1);
        sym_valid = 1'b1;
        sym_prob_upper = pu; sym_prob_lower = pl; sym_inv_total = inv; sym_last = last;
        @(posedge clk); #1;
        cyc0 = cyc;
        sym_valid = 1'b0;
        sym_prob_upper = ~pu; sym_prob_lower = ~pl; sym_inv_total = ~inv; sym_last = !last;
        chk("bc_work_upper", bc_work_upper, m_u[15:0]);
        chk("bc_work_lower", bc_work_lower, m_l[15:0]);
        chk("bc_prob_upper", bc_prob_upper, pu);
        chk("bc_prob_lower", bc_prob_lower, pl);
        chk("bc_prob_range", bc_prob_range, inv);
        chk("sym_ready_calc", sym_ready, 0);
        model_sym(ru, rl, last, edges);
        for (int k = 1; k <= int'(BC_LAT); k++) begin
            if (k == int'(BC_LAT)) begin
                bc_upper_res = ru; bc_lower_res = rl;
            end else begin
                bc_upper_res = 16'hDEAD ^ 16'(k); bc_lower_res = 16'hBEEF ^ 16'(k);
            end
            @(posedge clk); #1;
        end
        chk("bc_prob_upper_stable", bc_prob_upper, pu);
        bc_upper_res = 16'hDEAD; bc_lower_res = 16'hBEEF;
    endtask

    task automatic finish_sym(input int unsigned cyc0, input int unsigned edges_exp,
                              output int unsigned elapsed);
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (!sym_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("sym_ready_return", sym_ready, 1);
        elapsed = cyc - cyc0;
        chk("accept_to_idle_edges", elapsed, edges_exp);
        chk("bits_left", exp_bits.size(), 0);
        chk("done_left", done_pending, 0);
    endtask

    task automatic wait_bit_valid();
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (!bit_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bit_valid_seen", bit_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0, ed, el;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_ready", sym_ready, 1);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_bit_out", bit_out, 0);
        chk("rst_done", done, 0);
        chk("rst_pend_ovf", pend_ovf, 0);
        chk("rst_bc_work_upper", bc_work_upper, 0);
        chk("rst_bc_prob_range", bc_prob_range, 0);
        rst = 1'b0;

        // E1: single bit 0, nine cycles from accept cycle to the next ready cycle
        issue(16'h1234, 16'h0100, 17'h1ABCD, 1'b0, 16'h7FFF, 16'h0000, c0, ed);
        chk("e1_work_upper_lit", bc_work_upper, 16'hFFFF);
        finish_sym(c0, ed, el);
        chk("e1_cycles_lit", el + 1, 9);

        // E2: single bit 1
        issue(16'h8000, 16'h2000, 17'h00777, 1'b0, 16'hFFFF, 16'h8000, c0, ed);
        chk("e2_model_nbits", last_nb, 1);
        finish_sym(c0, ed, el);

        // E3 then idle with a pending bit
        issue(16'h4444, 16'h3333, 17'h10001, 1'b0, 16'hA000, 16'h5000, c0, ed);
        chk("e3_model_upper", m_u, 32'hC001);
        chk("e3_model_lower", m_l, 32'h2000);
        chk("e3_model_pend", m_p, 1);
        finish_sym(c0, ed, el);

        // Follow-up E1 releases the pending complement: bits 0,1 then a further E1 bit 0
        issue(16'h5555, 16'h0AAA, 17'h00100, 1'b0, 16'h3FFF, 16'h1000, c0, ed);
        chk("e3_dut_work_upper", bc_work_upper, 16'hC001);
        chk("e3_dut_work_lower", bc_work_lower, 16'h2000);
        chk("e3f_model_nbits", last_nb, 3);
        finish_sym(c0, ed, el);

        // Backpressure on an E1 bit: held for 11 EMIT cycles before release
        bit_ready = 1'b0;
        issue(16'h0F0F, 16'h00F0, 17'h0F0F0, 1'b0, 16'h7FFF, 16'h0000, c0, ed);
        wait_bit_valid();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bit_valid, 1);
            chk("bp_bit", bit_out, 0);
            chk("bp_sym_ready", sym_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bit_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_at_release", bit_valid, 1);
        @(posedge clk); #1;
        chk("bp_consumed", bit_valid, 0);
        finish_sym(c0, ed + 11, el);

        // Flush: last symbol, pending=1, bits 0,1 then a single done pulse
        issue(16'hC0DE, 16'h0123, 17'h1FFFF, 1'b1, 16'hBFFF, 16'h3000, c0, ed);
        chk("flush_model_nbits", last_nb, 2);
        finish_sym(c0, ed, el);

        // Reset while a bit is presented; stale datapath results must be ignored
        bit_ready = 1'b0;
        issue(16'h2222, 16'h1111, 17'h02222, 1'b0, 16'h7FFF, 16'h0000, c0, ed);
        chk("post_flush_work_upper", bc_work_upper, 16'hFFFF);
        chk("post_flush_work_lower", bc_work_lower, 16'h0000);
        wait_bit_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        bc_upper_res = 16'h7FFF; bc_lower_res = 16'h0000;
        @(posedge clk); #1;
        chk("mid_rst_bit_valid", bit_valid, 0);
        chk("mid_rst_sym_ready", sym_ready, 1);
        chk("mid_rst_bc_work_upper", bc_work_upper, 0);
        chk("mid_rst_bc_prob_upper", bc_prob_upper, 0);
        exp_bits.delete();
        m_u = 65535; m_l = 0; m_p = 0; done_pending = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bit_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stale_sym_ready", sym_ready, 1);
            chk("stale_bit_valid", bit_valid, 0);
        end
        bc_upper_res = 16'hDEAD; bc_lower_res = 16'hBEEF;

        issue(16'h3000, 16'h1000, 17'h00042, 1'b0, 16'hFFFF, 16'h8000, c0, ed);
        chk("after_rst_work_upper", bc_work_upper, 16'hFFFF);
        chk("after_rst_work_lower", bc_work_lower, 16'h0000);
        finish_sym(c0, ed, el);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
